fifo_uart_tx: RTL and testbench

Serial transmit stage that sits directly downstream of the synchronous FIFO on its consumer side. It pops DATA_WIDTH-bit words from the FIFO and sends each word on a single UART line as DATA_WIDTH/8 8N1 frames, least-significant byte first. It is the egress path from the core's output FIFO to the board-level TX pin.

---
 rtl/fifo_pkg.sv | 4 +
 rtl/uart_pkg.sv | 20 ++
 rtl/fifo_uart_tx_if.sv | 14 +
 rtl/uart_baud_cnt.sv | 27 ++
 rtl/fifo_uart_tx.sv | 140 ++++++++++++++
 tb/tb_fifo_uart_tx.sv | 250 +++++++++++++++++++++++++
 6 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO parameters used by the FIFO and its consumers.
package fifo_pkg;
  localparam int DATA_WIDTH = 16;
endpackage

// File: rtl/uart_pkg.sv
// UART transmit types and framing constants.
package uart_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } uart_tx_state_e;

  localparam int FRAME_BITS       = 10;
  localparam int BYTE_W           = 8;
  localparam int MIN_CLKS_PER_BIT = 2;

  // Cycles from start-bit entry to word_done for a word of n_bytes bytes.
  function automatic int word_cycles(input int n_bytes, input int clks_per_bit);
    return FRAME_BITS * n_bytes * clks_per_bit;
  endfunction
endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO consumer-side port. rd_en is a one-cycle pop request issued only while
// empty is low; rd_data holds the popped word from the following cycle on.
interface fifo_uart_tx_if #(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH
);
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  empty;
  logic                  full;
  logic                  rd_en;

  // master: the consumer that pops words; slave: the FIFO itself.
  modport master (input rd_data, input empty, input full, output rd_en);
  modport slave  (output rd_data, output empty, output full, input rd_en);
endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: tick marks the last cycle of each serial bit.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == TERM);

  // Count bit-period cycles; clear restarts the period on a state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/fifo_uart_tx.sv
// Pops words from the FIFO and sends them as back-to-back 8N1 frames,
// least-significant byte first. tx is decoded directly from registered state
// so reset forces the line high without waiting for a clock.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_WIDTH   = fifo_pkg::DATA_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fifo_uart_tx_if.master       fifo,
  input  logic                 tx_en,
  output logic                 tx,
  output logic                 busy,
  output logic                 word_done,
  output uart_tx_state_e       state
);
  localparam int NBYTES = DATA_WIDTH / BYTE_W;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  if (CLKS_PER_BIT < MIN_CLKS_PER_BIT) begin : g_bad_clks
    $error("fifo_uart_tx: CLKS_PER_BIT must be at least 2");
  end
  if ((DATA_WIDTH % BYTE_W) != 0 || DATA_WIDTH == 0) begin : g_bad_width
    $error("fifo_uart_tx: DATA_WIDTH must be a non-zero multiple of 8");
  end

  uart_tx_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0]   word_q;
  logic [BYTE_W-1:0]       shreg_q;
  logic [2:0]              bit_cnt_q;
  logic [IDX_W-1:0]        idx_q;
  logic                    rd_en;
  logic                    tick;
  logic                    baud_clear;

  // Hold the counter at zero outside serial states and on every state change.
  assign baud_clear = (state_d != state_q) || (state_q == IDLE) ||
                      (state_q == FETCH) || (state_q == LOAD);

  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (baud_clear),
    .tick  (tick)
  );

  assign fifo.rd_en = rd_en;
  assign busy       = (state_q != IDLE);
  assign state      = state_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d   = state_q;
    rd_en     = 1'b0;
    word_done = 1'b0;
    tx        = 1'b1;
    case (state_q)
      IDLE: begin
        if (tx_en && !fifo.empty) state_d = FETCH;
      end
      FETCH: begin
        rd_en   = 1'b1;
        state_d = LOAD;
      end
      LOAD: begin
        state_d = START;
      end
      START: begin
        tx = 1'b0;
        if (tick) state_d = DATA;
      end
      DATA: begin
        tx = shreg_q[0];
        if (tick && bit_cnt_q == 3'd7) state_d = STOP;
      end
      STOP: begin
        if (tick) begin
          if (idx_q != LAST_IDX) begin
            state_d = START;
          end else begin
            word_done = 1'b1;
            state_d   = (tx_en && !fifo.empty) ? FETCH : IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Word capture, byte selection and bit shifting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q    <= '0;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      idx_q     <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          word_q <= fifo.rd_data;
          idx_q  <= '0;
        end
        START: begin
          if (tick) begin
            shreg_q   <= word_q[int'(idx_q) * BYTE_W +: BYTE_W];
            bit_cnt_q <= '0;
          end
        end
        DATA: begin
          if (tick) begin
            shreg_q   <= shreg_q >> 1;
            bit_cnt_q <= bit_cnt_q + 3'd1;
          end
        end
        STOP: begin
          if (tick && idx_q != LAST_IDX) idx_q <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  a_rd_pulse: assert property (@(posedge clk) disable iff (!rst_n) rd_en |=> !rd_en);
  a_rd_empty: assert property (@(posedge clk) disable iff (!rst_n) !(rd_en && fifo.empty));
  a_tx_known: assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(tx));
  a_busy:     assert property (@(posedge clk) disable iff (!rst_n) busy == (state_q != IDLE));
  a_flags:    assert property (@(posedge clk) disable iff (!rst_n) !(fifo.full && fifo.empty));
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO model, serial-line monitor with byte
// scoreboard, and directed timing scenarios.
module tb_fifo_uart_tx;
  import uart_pkg::*;

  localparam int CLKS = 4;
  localparam int DW   = 16;
  localparam int WORD_LEN = 10 * (DW / 8) * CLKS;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic tx_en;
  logic tx, busy, word_done;
  uart_tx_state_e dut_state;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fifo_uart_tx_if #(.DATA_WIDTH(DW)) fifo_if ();

  fifo_uart_tx #(.CLKS_PER_BIT(CLKS), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fifo      (fifo_if),
    .tx_en     (tx_en),
    .tx        (tx),
    .busy      (busy),
    .word_done (word_done),
    .state     (dut_state)
  );

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- FIFO model ----------------
  logic [DW-1:0] fifo_q[$];
  logic [7:0]    exp_q[$];

  task automatic push_word(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    fifo_if.empty = 1'b0;
    for (int b = 0; b < DW / 8; b++) exp_q.push_back(w[b*8 +: 8]);
  endtask

  // Pop requested during a cycle takes effect just after the next edge.
  always begin
    logic pop;
    @(negedge clk);
    pop = (rst_n === 1'b1) && (fifo_if.rd_en === 1'b1);
    @(posedge clk);
    #1;
    if (pop && fifo_q.size() > 0) fifo_if.rd_data = fifo_q.pop_front();
    fifo_if.empty = (fifo_q.size() == 0);
  end

  // ---------------- event counters ----------------
  int rd_cnt = 0, wd_cnt = 0, viol = 0;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (fifo_if.rd_en === 1'b1) rd_cnt++;
      if (fifo_if.rd_en === 1'b1 && fifo_if.empty === 1'b1) viol++;
      if (word_done === 1'b1) wd_cnt++;
    end
  end

  // ---------------- serial monitor / scoreboard ----------------
  int mon_gen = 0;

  task automatic rx_frame();
    int g;
    logic [7:0] b;
    logic [7:0] e;
    g = mon_gen;
    b = '0;
    repeat (CLKS / 2) @(negedge clk);
    if (g != mon_gen) return;
    chk("start_bit", 32'(tx), 32'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (CLKS) @(negedge clk);
      if (g != mon_gen) return;
      b[i] = tx;
    end
    repeat (CLKS) @(negedge clk);
    if (g != mon_gen) return;
    chk("stop_bit", 32'(tx), 32'd1);
    if (exp_q.size() == 0) begin
      chk("unexpected_byte", 32'(b), 32'hFFFF_FFFF);
    end else begin
      e = exp_q.pop_front();
      chk("rx_byte", 32'(b), 32'(e));
    end
  endtask

  always begin
    @(negedge clk);
    if (rst_n === 1'b1 && tx === 1'b0) rx_frame();
  end

  // ---------------- driver helpers ----------------
  // which: 0 = rd_en, 1 = tx low, 2 = word_done. Returns cycle stamp or -1.
  task automatic wait_for(input string tag, input int which, input int budget, output int c);
    c = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((which == 0 && fifo_if.rd_en === 1'b1) ||
          (which == 1 && tx === 1'b0) ||
          (which == 2 && word_done === 1'b1)) begin
        c = cyc;
        return;
      end
    end
    chk({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int rc, sc, wc, s2, r0, w0, lows, busys, rds;
    rst_n = 1'b0;
    tx_en = 1'b0;
    fifo_if.full = 1'b0;
    fifo_if.empty = 1'b1;
    fifo_if.rd_data = '0;

    // Reset state and idle with an empty FIFO.
    #12;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd_en", 32'(fifo_if.rd_en), 32'd0);
    chk("rst_word_done", 32'(word_done), 32'd0);
    chk("rst_state", 32'(dut_state), 32'(IDLE));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    tx_en = 1'b1;
    lows = 0; busys = 0; rds = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
      if (busy !== 1'b0) busys++;
      if (fifo_if.rd_en !== 1'b0) rds++;
    end
    chk("idle_tx_low", 32'(lows), 32'd0);
    chk("idle_busy", 32'(busys), 32'd0);
    chk("idle_rd_en", 32'(rds), 32'd0);

    // Single word: latency and word length.
    r0 = rd_cnt; w0 = wd_cnt;
    push_word(16'hA53C);
    wait_for("single_rd", 0, 10, rc);
    wait_for("single_start", 1, 10, sc);
    chk("single_latency", 32'(sc - rc), 32'd2);
    wait_for("single_done", 2, 200, wc);
    chk("single_word_len", 32'(wc - sc + 1), 32'(WORD_LEN));
    repeat (5) @(negedge clk);
    chk("single_rd_cnt", 32'(rd_cnt - r0), 32'd1);
    chk("single_wd_cnt", 32'(wd_cnt - w0), 32'd1);
    chk("single_idle_busy", 32'(busy), 32'd0);

    // Back-to-back words: two idle-high cycles between them.
    r0 = rd_cnt; w0 = wd_cnt;
    push_word(16'h0001);
    push_word(16'hFFFF);
    wait_for("b2b_done1", 2, 250, wc);
    wait_for("b2b_start2", 1, 10, s2);
    chk("b2b_gap", 32'(s2 - wc - 1), 32'd2);
    wait_for("b2b_done2", 2, 250, wc);
    chk("b2b_word2_len", 32'(wc - s2 + 1), 32'(WORD_LEN));
    repeat (5) @(negedge clk);
    chk("b2b_rd_cnt", 32'(rd_cnt - r0), 32'd2);
    chk("b2b_wd_cnt", 32'(wd_cnt - w0), 32'd2);

    // tx_en dropped mid-word: the word finishes, no further fetch.
    r0 = rd_cnt; w0 = wd_cnt;
    push_word(16'h1234);
    push_word(16'h5678);
    wait_for("gate_rd", 0, 10, rc);
    wait_for("gate_start", 1, 10, sc);
    repeat (CLKS * 3) @(negedge clk);
    chk("gate_in_data", 32'(dut_state), 32'(DATA));
    tx_en = 1'b0;
    wait_for("gate_done1", 2, 200, wc);
    repeat (40) @(negedge clk);
    chk("gate_rd_held", 32'(rd_cnt - r0), 32'd1);
    chk("gate_busy", 32'(busy), 32'd0);
    chk("gate_state", 32'(dut_state), 32'(IDLE));
    tx_en = 1'b1;
    @(negedge clk);
    chk("gate_fetch_next", 32'(fifo_if.rd_en), 32'd1);
    wait_for("gate_done2", 2, 200, wc);
    repeat (5) @(negedge clk);
    chk("gate_rd_cnt", 32'(rd_cnt - r0), 32'd2);
    chk("gate_wd_cnt", 32'(wd_cnt - w0), 32'd2);

    // Reset during bit 3 of byte 0: word discarded, next word fetched fresh.
    r0 = rd_cnt;
    push_word(16'hBEEF);
    push_word(16'hC0DE);
    wait_for("rst_rd", 0, 10, rc);
    wait_for("rst_start", 1, 10, sc);
    repeat (CLKS * 4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    mon_gen++;
    repeat (DW / 8) if (exp_q.size() > 0) void'(exp_q.pop_front());
    #1;
    chk("rst_mid_tx", 32'(tx), 32'd1);
    chk("rst_mid_state", 32'(dut_state), 32'(IDLE));
    chk("rst_mid_busy", 32'(busy), 32'd0);
    repeat (8) @(negedge clk);
    rst_n = 1'b1;
    wait_for("rst_refetch", 0, 5, rc);
    wait_for("rst_start2", 1, 10, sc);
    chk("rst_latency", 32'(sc - rc), 32'd2);
    wait_for("rst_done", 2, 200, wc);
    repeat (5) @(negedge clk);
    chk("rst_rd_cnt", 32'(rd_cnt - r0), 32'd2);
    chk("rst_fifo_drained", 32'(fifo_q.size()), 32'd0);

    // FIFO runs empty exactly at word_done.
    r0 = rd_cnt;
    push_word(16'h0F0F);
    wait_for("empty_done", 2, 250, wc);
    @(negedge clk);
    chk("empty_state", 32'(dut_state), 32'(IDLE));
    repeat (20) @(negedge clk);
    chk("empty_busy", 32'(busy), 32'd0);
    chk("empty_rd_cnt", 32'(rd_cnt - r0), 32'd1);
    chk("rd_while_empty", 32'(viol), 32'd0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
